dma_channel: RTL and testbench

Single-channel DMA engine that sits on the requester side of the system bus arbiter. It raises `dma_req`, waits for `bus_grant`, and copies a programmed block of words from a source address to a destination address, one word at a time. Each word is a read followed by a write. The channel gives the bus back every `BURST_MAX` words so the CPU can reach the bus during long transfers. The CPU programs and starts it through a simple start/done control port.

---
 rtl/dma_pkg.sv | 17 +
 rtl/dma_channel.sv | 196 +++++++++++++++++++
 tb/tb_dma_channel.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA engine.
// Holds the controller state encoding and its width so other blocks
// (monitors, debug taps) can decode the state without duplicating it.
package dma_pkg;

    localparam int DMA_STATE_W = 3;

    typedef enum logic [DMA_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_REL  = 3'd4,
        ST_FIN  = 3'd5
    } dma_state_e;

endpackage

// File: rtl/dma_channel.sv
// Single-channel DMA: copies xfer_len words src->dst, one read then one write per word.
// Latency: busy/dma_req one cycle after start; 2 cycles per word with zero wait states.
// Backpressure: bus_ready stalls an access in place; losing bus_grant mid-access drops
// the strobe and re-requests, retrying the same access. Bus released every BURST_MAX words.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   start, src_addr, dst_addr,
//   xfer_len                      CPU control; sampled only in IDLE
//   busy, done                    status; done is a one-cycle pulse
//   dma_req, bus_grant            arbiter handshake
//   bus_addr, bus_rd, bus_wr,
//   bus_wdata, bus_rdata,
//   bus_ready                     requester-side bus; outputs decode registered state only
module dma_channel
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic              busy,
    output logic              done,
    output logic              dma_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    // Burst counter must be able to hold BURST_MAX itself.
    localparam int BURST_W = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
    // Value of burst_q when the write now completing is the last of the tenure.
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

    dma_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   src_q,   src_d;
    logic [ADDR_W-1:0]   dst_q,   dst_d;
    logic [LEN_W-1:0]    rem_q,   rem_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [DATA_W-1:0]   buf_q,   buf_d;
    logic                phase_q, phase_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            burst_q <= '0;
            buf_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            burst_q <= burst_d;
            buf_q   <= buf_d;
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        burst_d = burst_q;
        buf_d   = buf_q;
        phase_d = phase_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (xfer_len != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        rem_d   = xfer_len;
                        burst_d = '0;
                        phase_d = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        // Empty transfer: report completion without touching the bus.
                        state_d = ST_FIN;
                    end
                end
            end

            ST_REQ: begin
                // phase_q resumes an interrupted word at the access it stopped on.
                if (bus_grant) begin
                    state_d = phase_q ? ST_WR : ST_RD;
                end
            end

            ST_RD: begin
                // A completing access wins over a simultaneous grant loss.
                if (bus_ready) begin
                    buf_d   = bus_rdata;
                    src_d   = src_q + ADDR_W'(1);
                    phase_d = 1'b1;
                    state_d = ST_WR;
                end else if (!bus_grant) begin
                    state_d = ST_REQ;
                end
            end

            ST_WR: begin
                if (bus_ready) begin
                    dst_d   = dst_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    burst_d = burst_q + BURST_W'(1);
                    phase_d = 1'b0;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_FIN;
                    end else if (burst_q == BURST_LAST) begin
                        state_d = ST_REL;
                    end else begin
                        state_d = ST_RD;
                    end
                end else if (!bus_grant) begin
                    state_d = ST_REQ;
                end
            end

            ST_REL: begin
                // One idle cycle with dma_req low lets the arbiter hand the bus over.
                burst_d = '0;
                state_d = ST_REQ;
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: depends on registered state only, so there is no
    // combinational path from bus_grant/bus_ready to any output.
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        dma_req   = 1'b0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;

        unique case (state_q)
            ST_REQ: begin
                dma_req = 1'b1;
            end
            ST_RD: begin
                dma_req  = 1'b1;
                bus_rd   = 1'b1;
                bus_addr = src_q;
            end
            ST_WR: begin
                dma_req   = 1'b1;
                bus_wr    = 1'b1;
                bus_addr  = dst_q;
                bus_wdata = buf_q;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
                // IDLE and REL drive every bus output low.
            end
        endcase
    end

endmodule

// File: tb/tb_dma_channel.sv
module tb_dma_channel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [7:0]  xfer_len = '0;
    logic        busy, done, dma_req;
    logic        grant = 1'b1;
    logic [15:0] bus_addr;
    logic        bus_rd, bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ready;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int ws = 0;
    int wait_cnt = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q [$];
    logic [23:0] wr_q [$];

    logic        prev_stb = 1'b0, prev_rdy = 1'b0, prev_rd = 1'b0;
    logic [15:0] prev_addr = '0;

    always #5 clk = ~clk;

    dma_channel dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .xfer_len  (xfer_len),
        .busy      (busy),
        .done      (done),
        .dma_req   (dma_req),
        .bus_grant (grant),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    // Memory slave: ready after ws wait cycles on each strobed access.
    assign bus_ready = (bus_rd || bus_wr) && (wait_cnt >= ws);
    assign bus_rdata = mem[bus_addr];

    always @(posedge clk) begin
        if ((bus_rd || bus_wr) && !bus_ready) wait_cnt <= wait_cnt + 1;
        else                                   wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor and scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_rd || bus_wr) begin
                chk("rd_wr_exclusive", {31'd0, bus_rd && bus_wr}, 32'd0);
                chk("strobe_needs_req", {31'd0, dma_req}, 32'd1);
            end
            if (prev_stb && !prev_rdy && (bus_rd || bus_wr)) begin
                chk("wait_strobe_stable", {31'd0, bus_rd}, {31'd0, prev_rd});
                chk("wait_addr_stable", {16'd0, bus_addr}, {16'd0, prev_addr});
            end
            if (bus_rd && bus_ready) begin
                acc_cnt++;
                if (rd_q.size() == 0) chk("unexpected_read", {16'd0, bus_addr}, 32'hFFFF_FFFF);
                else chk("read_addr", {16'd0, bus_addr}, {16'd0, rd_q.pop_front()});
            end
            if (bus_wr && bus_ready) begin
                acc_cnt++;
                if (wr_q.size() == 0) chk("unexpected_write", {8'd0, bus_addr, bus_wdata}, 32'hFFFF_FFFF);
                else chk("write_addr_data", {8'd0, bus_addr, bus_wdata}, {8'd0, wr_q.pop_front()});
                mem[bus_addr] = bus_wdata;
            end
        end
        prev_stb  = bus_rd || bus_wr;
        prev_rdy  = bus_ready;
        prev_rd   = bus_rd;
        prev_addr = bus_addr;
    end

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  len;
        int          wst;
        int          exp_lat;   // cycles from start sample to done
        int          exp_req;   // cycles with dma_req high
        int          exp_acc;   // completed bus accesses
    } vec_t;

    vec_t vecs [8];

    task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        xfer_len = l;
        start    = 1'b1;
        for (int i = 0; i < int'(l); i++) begin
            logic [15:0] sa, da;
            sa = s + 16'(i);
            da = d + 16'(i);
            rd_q.push_back(sa);
            wr_q.push_back({da, mem[sa]});
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_req"},  {31'd0, dma_req}, 32'd0);
        chk({tag, "_rdwr"}, {30'd0, bus_rd, bus_wr}, 32'd0);
        chk({tag, "_addr"}, {16'd0, bus_addr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, bus_wdata}, 32'd0);
    endtask

    initial begin
        int lat, reqc, donec;
        logic dropped;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        vecs[0] = '{16'h0010, 16'h0100, 8'd3, 0, 8,  7,  6};
        vecs[1] = '{16'h0200, 16'h0300, 8'd6, 0, 16, 14, 12};
        vecs[2] = '{16'h0400, 16'h0500, 8'd1, 0, 4,  3,  2};
        vecs[3] = '{16'h0600, 16'h0700, 8'd4, 0, 10, 9,  8};
        vecs[4] = '{16'h0800, 16'h0900, 8'd5, 0, 14, 12, 10};
        vecs[5] = '{16'h0A00, 16'h0B00, 8'd2, 3, 18, 17, 4};
        vecs[6] = '{16'h0C00, 16'h0D00, 8'd0, 0, 1,  0,  0};
        vecs[7] = '{16'hFFFF, 16'h0E00, 8'd2, 0, 6,  5,  4};

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Table-driven transfers
        for (int v = 0; v < 8; v++) begin
            ws = vecs[v].wst;
            acc_cnt = 0;
            launch(vecs[v].src, vecs[v].dst, vecs[v].len);
            lat = -1; reqc = 0;
            for (int c = 1; c <= 600 && lat < 0; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (dma_req) reqc++;
                if (done) lat = c;
            end
            chk($sformatf("v%0d_done_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_req_cycles", v), reqc, vecs[v].exp_req);
            chk($sformatf("v%0d_accesses", v), acc_cnt, vecs[v].exp_acc);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", v), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_idle_after", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_sb_empty", v), rd_q.size() + wr_q.size(), 0);
        end
        ws = 0;

        // Grant lost during the second word's write
        ws = 1; acc_cnt = 0; dropped = 1'b0; lat = -1;
        launch(16'h1000, 16'h1100, 8'd3);
        for (int c = 1; c <= 600 && lat < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) lat = c;
            if (!dropped && bus_wr && bus_addr == 16'h1101 && !bus_ready) begin
                grant = 1'b0;
                dropped = 1'b1;
                @(negedge clk);
                chk("grant_lost_strobe_dropped", {30'd0, bus_rd, bus_wr}, 32'd0);
                chk("grant_lost_req_held", {31'd0, dma_req}, 32'd1);
                @(negedge clk);
                grant = 1'b1;
            end
        end
        chk("grant_lost_dropped", {31'd0, dropped}, 32'd1);
        chk("grant_lost_done", {31'd0, lat > 0}, 32'd1);
        chk("grant_lost_accesses", acc_cnt, 6);
        for (int i = 0; i < 3; i++)
            chk($sformatf("grant_lost_dst%0d", i), {24'd0, mem[16'h1100 + 16'(i)]},
                {24'd0, mem[16'h1000 + 16'(i)]});
        chk("grant_lost_sb_empty", rd_q.size() + wr_q.size(), 0);
        ws = 0;

        // Start while busy is ignored
        acc_cnt = 0; donec = 0;
        launch(16'h1200, 16'h1300, 8'd3);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        src_addr = 16'h1400; dst_addr = 16'h1500; xfer_len = 8'd5; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) donec++;
        end
        chk("busy_start_done_count", donec, 1);
        chk("busy_start_accesses", acc_cnt, 6);
        chk("busy_start_sb_empty", rd_q.size() + wr_q.size(), 0);

        // Reset mid-transfer
        launch(16'h1600, 16'h1700, 8'd6);
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        rst = 1'b0;
        donec = 0; reqc = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) donec++;
            if (dma_req || busy) reqc++;
        end
        chk("midreset_no_done", donec, 0);
        chk("midreset_stays_idle", reqc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
